// File: rtl/tlul_gpio_slave.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tlul_gpio_slave : TL-UL slave exposing a GPIO register file with rising-edge
//                   interrupts. Optional macro GPIO_MASKED_WRITE_EN.
// Revision        : 1.0
// ----------------------------------------------------------------------------
module tlul_gpio_slave #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MASK_WIDTH   = DATA_WIDTH/8,
  parameter int SIZE_WIDTH   = 3,
  parameter int SRC_WIDTH    = 2,
  parameter int SINK_WIDTH   = 1,
  parameter int OPCODE_WIDTH = 3,
  parameter int PARAM_WIDTH  = 3,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [OPCODE_WIDTH-1:0] a_opcode,
  input  logic [PARAM_WIDTH-1:0]  a_param,
  input  logic [SIZE_WIDTH-1:0]   a_size,
  input  logic [SRC_WIDTH-1:0]    a_source,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  input  logic [MASK_WIDTH-1:0]   a_mask,
  input  logic [DATA_WIDTH-1:0]   a_data,
  output logic                    d_valid,
  input  logic                    d_ready,
  output logic [OPCODE_WIDTH-1:0] d_opcode,
  output logic [PARAM_WIDTH-1:0]  d_param,
  output logic [SIZE_WIDTH-1:0]   d_size,
  output logic [SRC_WIDTH-1:0]    d_source,
  output logic [SINK_WIDTH-1:0]   d_sink,
  output logic [DATA_WIDTH-1:0]   d_data,
  output logic                    d_error,
  input  logic [DATA_WIDTH-1:0]   gpio_i,
  output logic [DATA_WIDTH-1:0]   gpio_o,
  output logic [DATA_WIDTH-1:0]   gpio_oe,
  output logic                    intr_o
);

  localparam logic [OPCODE_WIDTH-1:0] OP_PUT_FULL = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_PUT_PART = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_GET      = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] D_ACK       = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] D_ACK_DATA  = OPCODE_WIDTH'(1);
`ifdef GPIO_MASKED_WRITE_EN
  localparam int HALF = DATA_WIDTH/2;
`endif

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;

  state_e                  state_q;
  logic                    a_ready_q, d_valid_q, d_error_q;
  logic [OPCODE_WIDTH-1:0] d_opcode_q;
  logic [SIZE_WIDTH-1:0]   d_size_q;
  logic [SRC_WIDTH-1:0]    d_source_q;
  logic [DATA_WIDTH-1:0]   d_data_q;

  logic [DATA_WIDTH-1:0] sync1_q, sync_q, prev_q;
  logic [DATA_WIDTH-1:0] out_q, out_d, dir_q, dir_d, ist_q, ist_d, ien_q, ien_d;

  logic                  accept, in_win, is_get, is_put, full_mask, err, do_wr;
  logic [ADDR_WIDTH-1:0] offset;
  logic [3:0]            reg_idx;
  logic [DATA_WIDTH-1:0] bmask, rdata;
  logic                  sel_out, sel_dir, sel_ist, sel_ien;
`ifdef GPIO_MASKED_WRITE_EN
  logic                  sel_mlo, sel_mhi;
`endif

  assign accept    = a_valid & a_ready_q;
  // Unsigned subtraction folds the below-base case into the same range check.
  assign offset    = a_address - BASE_ADDR;
  assign in_win    = (offset < ADDR_WIDTH'(64));
  assign reg_idx   = offset[5:2];
  assign is_get    = (a_opcode == OP_GET);
  assign is_put    = (a_opcode == OP_PUT_FULL) | (a_opcode == OP_PUT_PART);
  assign full_mask = &a_mask;

  always_comb begin
    bmask = '0;
    for (int i = 0; i < MASK_WIDTH; i++) begin
      bmask[8*i +: 8] = {8{a_mask[i]}};
    end
  end

  always_comb begin
    err     = 1'b0;
    rdata   = '0;
    sel_out = 1'b0;
    sel_dir = 1'b0;
    sel_ist = 1'b0;
    sel_ien = 1'b0;
`ifdef GPIO_MASKED_WRITE_EN
    sel_mlo = 1'b0;
    sel_mhi = 1'b0;
`endif
    if (!in_win || (a_address[1:0] != 2'b00) || (a_size != SIZE_WIDTH'(2)) ||
        !(is_get || is_put)) begin
      err = 1'b1;
    end else begin
      case (reg_idx)
        4'd0: begin rdata = sync_q; err = is_put; end
        4'd1: begin rdata = out_q;  sel_out = 1'b1; end
        4'd2: begin rdata = dir_q;  sel_dir = 1'b1; end
        4'd3: begin rdata = ist_q;  sel_ist = 1'b1; end
        4'd4: begin rdata = ien_q;  sel_ien = 1'b1; end
`ifdef GPIO_MASKED_WRITE_EN
        4'd5: begin sel_mlo = 1'b1; err = is_put & ~full_mask; end
        4'd6: begin sel_mhi = 1'b1; err = is_put & ~full_mask; end
`endif
        default: err = 1'b1;
      endcase
    end
    if ((a_opcode == OP_PUT_FULL) && !full_mask) begin
      err = 1'b1;
    end
  end

  assign do_wr = accept & is_put & ~err;

  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    ien_d = ien_q;
    // New rising edges are OR-ed in after the clear so a coincident set wins.
    ist_d = (ist_q & ~((do_wr && sel_ist) ? (a_data & bmask) : '0)) | (sync_q & ~prev_q);
    if (do_wr && sel_out) out_d = (out_q & ~bmask) | (a_data & bmask);
    if (do_wr && sel_dir) dir_d = (dir_q & ~bmask) | (a_data & bmask);
    if (do_wr && sel_ien) ien_d = (ien_q & ~bmask) | (a_data & bmask);
`ifdef GPIO_MASKED_WRITE_EN
    if (do_wr && sel_mlo) begin
      for (int i = 0; i < HALF; i++) if (a_data[HALF+i]) out_d[i] = a_data[i];
    end
    if (do_wr && sel_mhi) begin
      for (int i = 0; i < HALF; i++) if (a_data[HALF+i]) out_d[HALF+i] = a_data[i];
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync_q  <= '0;
      prev_q  <= '0;
      out_q   <= '0;
      dir_q   <= '0;
      ist_q   <= '0;
      ien_q   <= '0;
    end else begin
      sync1_q <= gpio_i;
      sync_q  <= sync1_q;
      prev_q  <= sync_q;
      out_q   <= out_d;
      dir_q   <= dir_d;
      ist_q   <= ist_d;
      ien_q   <= ien_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      a_ready_q  <= 1'b1;
      d_valid_q  <= 1'b0;
      d_opcode_q <= '0;
      d_size_q   <= '0;
      d_source_q <= '0;
      d_data_q   <= '0;
      d_error_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          state_q    <= RESP;
          a_ready_q  <= 1'b0;
          d_valid_q  <= 1'b1;
          d_opcode_q <= is_get ? D_ACK_DATA : D_ACK;
          d_size_q   <= a_size;
          d_source_q <= a_source;
          d_error_q  <= err;
          d_data_q   <= (is_get && !err) ? rdata : '0;
        end
        RESP: if (d_ready) begin
          state_q   <= IDLE;
          a_ready_q <= 1'b1;
          d_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_ready  = a_ready_q;
  assign d_valid  = d_valid_q;
  assign d_opcode = d_opcode_q;
  assign d_param  = '0;
  assign d_size   = d_size_q;
  assign d_source = d_source_q;
  assign d_sink   = '0;
  assign d_data   = d_data_q;
  assign d_error  = d_error_q;
  assign gpio_o   = out_q;
  assign gpio_oe  = dir_q;
  assign intr_o   = |(ist_q & ien_q);

  logic unused_ok;
  assign unused_ok = ^{a_param, offset[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_tlul_gpio_slave.sv
`default_nettype none
// Bench for tlul_gpio_slave: directed test-plan checks plus randomized traffic
// compared every cycle against a transaction-level register model.
module tb_tlul_gpio_slave;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid, a_ready, d_valid, d_ready, d_error, intr_o;
  logic [2:0]  a_opcode, a_param, a_size, d_opcode, d_param, d_size;
  logic [1:0]  a_source, d_source;
  logic [31:0] a_address, a_data, d_data, gpio_i, gpio_o, gpio_oe;
  logic [3:0]  a_mask;
  logic [0:0]  d_sink;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tlul_gpio_slave dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_data(d_data),
    .d_error(d_error),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .intr_o(intr_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_out = '0, m_dir = '0, m_ist = '0, m_ien = '0;
  logic [31:0] hist [0:2] = '{32'h0, 32'h0, 32'h0};  // gpio_i at the last three edges
  logic        m_pend = 1'b0, m_err = 1'b0;
  logic [2:0]  m_dop = '0, m_size = '0;
  logic [1:0]  m_src = '0;
  logic [31:0] m_data = '0;

  function automatic logic [31:0] bytes(input logic [3:0] m);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic void decode(input logic [2:0] op, input logic [31:0] addr,
                                 input logic [2:0] size, input logic [3:0] mask,
                                 output logic err, output logic [31:0] rd, output int idx);
    logic [31:0] off;
    bit get, put;
    off = addr - BASE;
    get = (op == 3'd4);
    put = (op == 3'd0) || (op == 3'd1);
    err = 1'b0;
    rd  = '0;
    idx = int'(off / 4);
    if (off > 63 || addr % 4 != 0 || size != 3'd2 || !(get || put) ||
        (op == 3'd0 && mask != 4'hF)) begin
      err = 1'b1;
    end else begin
      case (idx)
        0: if (put) err = 1'b1; else rd = hist[1];
        1: rd = m_out;
        2: rd = m_dir;
        3: rd = m_ist;
        4: rd = m_ien;
`ifdef GPIO_MASKED_WRITE_EN
        5, 6: if (put && mask != 4'hF) err = 1'b1;
`endif
        default: err = 1'b1;
      endcase
    end
  endfunction

  always @(posedge clk or negedge reset) begin
    logic [31:0] clr, bm, rise, rd;
    logic        e;
    int          idx;
    if (!reset) begin
      m_out = '0; m_dir = '0; m_ist = '0; m_ien = '0;
      hist[0] = '0; hist[1] = '0; hist[2] = '0;
      m_pend = 1'b0; m_err = 1'b0; m_dop = '0; m_size = '0; m_src = '0; m_data = '0;
    end else begin
      clr  = '0;
      rise = hist[1] & ~hist[2];
      if (m_pend) begin
        if (d_ready) m_pend = 1'b0;
      end else if (a_valid) begin
        decode(a_opcode, a_address, a_size, a_mask, e, rd, idx);
        m_pend = 1'b1;
        m_err  = e;
        m_dop  = (a_opcode == 3'd4) ? 3'd1 : 3'd0;
        m_data = (a_opcode == 3'd4 && !e) ? rd : 32'h0;
        m_src  = a_source;
        m_size = a_size;
        bm     = bytes(a_mask);
        if (!e && a_opcode != 3'd4) begin
          case (idx)
            1: m_out = (m_out & ~bm) | (a_data & bm);
            2: m_dir = (m_dir & ~bm) | (a_data & bm);
            3: clr   = a_data & bm;
            4: m_ien = (m_ien & ~bm) | (a_data & bm);
            5: for (int i = 0; i < 16; i++) if (a_data[16+i]) m_out[i] = a_data[i];
            6: for (int i = 0; i < 16; i++) if (a_data[16+i]) m_out[16+i] = a_data[i];
            default: ;
          endcase
        end
      end
      m_ist   = (m_ist & ~clr) | rise;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = gpio_i;
    end
  end

  always @(negedge clk) begin
    chk("a_ready", 32'(a_ready), 32'(!m_pend));
    chk("d_valid", 32'(d_valid), 32'(m_pend));
    chk("gpio_o", gpio_o, m_out);
    chk("gpio_oe", gpio_oe, m_dir);
    chk("intr_o", 32'(intr_o), 32'(|(m_ist & m_ien)));
    if (m_pend) begin
      chk("d_opcode", 32'(d_opcode), 32'(m_dop));
      chk("d_data", d_data, m_data);
      chk("d_error", 32'(d_error), 32'(m_err));
      chk("d_source", 32'(d_source), 32'(m_src));
      chk("d_size", 32'(d_size), 32'(m_size));
      chk("d_param", 32'(d_param), 32'h0);
      chk("d_sink", 32'(d_sink), 32'h0);
    end
  end

  // Starts at a negedge with d_ready=1, returns at a negedge with the slave idle.
  task automatic txn(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                     input logic [31:0] data, input logic [1:0] src,
                     output logic [31:0] rd, output logic err, output logic [2:0] dop);
    int n = 0;
    a_valid = 1'b1; a_opcode = op; a_address = addr; a_mask = mask; a_data = data;
    a_size = 3'd2; a_source = src; a_param = 3'($urandom);
    while (!a_ready && n < 16) begin @(negedge clk); n++; end
    chk("txn_accept_timeout", 32'(n < 16), 32'h1);
    @(negedge clk);
    a_valid = 1'b0;
    chk("txn_latency", 32'(d_valid), 32'h1);
    chk("txn_source", 32'(d_source), 32'(src));
    rd = d_data; err = d_error; dop = d_opcode;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    logic [2:0]  dop;
    int          r;
    a_valid = 0; a_opcode = 0; a_param = 0; a_size = 3'd2; a_source = 0;
    a_address = 0; a_mask = 0; a_data = 0; d_ready = 1; gpio_i = 0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_a_ready", 32'(a_ready), 32'h1);
    chk("rst_d_valid", 32'(d_valid), 32'h0);
    chk("rst_d_data", d_data, 32'h0);
    chk("rst_d_opcode", 32'(d_opcode), 32'h0);
    chk("rst_gpio_o", gpio_o, 32'h0);
    chk("rst_intr_o", 32'(intr_o), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    txn(3'd4, BASE + 32'h4, 4'hF, 32'h0, 2'd2, rd, e, dop);
    chk("get0_opcode", 32'(dop), 32'h1);
    chk("get0_data", rd, 32'h0);
    chk("get0_error", 32'(e), 32'h0);

    txn(3'd0, BASE + 32'h4, 4'hF, 32'hDEAD_BEEF, 2'd0, rd, e, dop);
    chk("put_full_opcode", 32'(dop), 32'h0);
    txn(3'd4, BASE + 32'h4, 4'h0, 32'h0, 2'd1, rd, e, dop);
    chk("readback", rd, 32'hDEAD_BEEF);
    chk("gpio_o_full", gpio_o, 32'hDEAD_BEEF);
    txn(3'd1, BASE + 32'h4, 4'h2, 32'h0000_5500, 2'd3, rd, e, dop);
    chk("gpio_o_partial", gpio_o, 32'hDEAD_55EF);

    txn(3'd4, BASE + 32'h2, 4'hF, 32'h0, 2'd0, rd, e, dop);
    chk("misaligned_err", 32'(e), 32'h1);
    chk("misaligned_data", rd, 32'h0);
    txn(3'd4, BASE + 32'h100, 4'hF, 32'h0, 2'd0, rd, e, dop);
    chk("outside_err", 32'(e), 32'h1);
    gpio_i = 32'h0000_1234;
    repeat (3) @(negedge clk);
    txn(3'd0, BASE, 4'hF, 32'hFFFF_FFFF, 2'd0, rd, e, dop);
    chk("datain_write_err", 32'(e), 32'h1);
    txn(3'd4, BASE, 4'hF, 32'h0, 2'd0, rd, e, dop);
    chk("datain_read", rd, 32'h0000_1234);
    txn(3'd0, BASE + 32'h8, 4'h7, 32'h0, 2'd0, rd, e, dop);
    chk("putfull_partial_err", 32'(e), 32'h1);

    // Back-pressure: response held, a competing request must wait.
    a_valid = 1; a_opcode = 3'd4; a_address = BASE + 32'h4; a_mask = 4'hF; a_source = 2'd1;
    d_ready = 0;
    @(negedge clk);
    a_opcode = 3'd0; a_address = BASE + 32'h8; a_data = 32'h0000_FF00; a_source = 2'd2;
    for (int i = 0; i < 5; i++) begin
      chk("bp_d_valid", 32'(d_valid), 32'h1);
      chk("bp_a_ready", 32'(a_ready), 32'h0);
      chk("bp_d_data", d_data, 32'hDEAD_55EF);
      chk("bp_d_source", 32'(d_source), 32'h1);
      @(negedge clk);
    end
    d_ready = 1;
    @(negedge clk);
    chk("bp_released_a_ready", 32'(a_ready), 32'h1);
    chk("bp_released_d_valid", 32'(d_valid), 32'h0);
    @(negedge clk);
    chk("bp_next_accept", 32'(d_valid), 32'h1);
    chk("bp_next_opcode", 32'(d_opcode), 32'h0);
    a_valid = 0;
    @(negedge clk);
    chk("dir_written", gpio_oe, 32'h0000_FF00);

    // Interrupts
    txn(3'd0, BASE + 32'h10, 4'hF, 32'h1, 2'd0, rd, e, dop);
    txn(3'd0, BASE + 32'hC, 4'hF, 32'hFFFF_FFFF, 2'd0, rd, e, dop);
    chk("intr_cleared", 32'(intr_o), 32'h0);
    gpio_i[0] = 1'b1;
    @(negedge clk); chk("intr_lat1", 32'(intr_o), 32'h0);
    @(negedge clk); chk("intr_lat2", 32'(intr_o), 32'h0);
    @(negedge clk); chk("intr_lat3", 32'(intr_o), 32'h1);
    txn(3'd4, BASE + 32'hC, 4'hF, 32'h0, 2'd0, rd, e, dop);
    chk("intr_state", rd, 32'h1);
    txn(3'd0, BASE + 32'hC, 4'hF, 32'h1, 2'd0, rd, e, dop);
    chk("intr_w1c", 32'(intr_o), 32'h0);
    gpio_i[0] = 1'b0;
    repeat (4) @(negedge clk);
    gpio_i[0] = 1'b1;
    repeat (2) @(negedge clk);
    txn(3'd0, BASE + 32'hC, 4'hF, 32'h1, 2'd0, rd, e, dop);
    chk("set_wins_intr", 32'(intr_o), 32'h1);
    txn(3'd4, BASE + 32'hC, 4'hF, 32'h0, 2'd0, rd, e, dop);
    chk("set_wins_state", rd, 32'h1);

    // Masked output write
    txn(3'd0, BASE + 32'h4, 4'hF, 32'h0, 2'd0, rd, e, dop);
    txn(3'd0, BASE + 32'h14, 4'hF, 32'h00FF_00A5, 2'd0, rd, e, dop);
`ifdef GPIO_MASKED_WRITE_EN
    chk("masked_err", 32'(e), 32'h0);
    chk("masked_gpio_o", gpio_o, 32'h0000_00A5);
    txn(3'd4, BASE + 32'h14, 4'hF, 32'h0, 2'd0, rd, e, dop);
    chk("masked_read_zero", rd, 32'h0);
`else
    chk("masked_err", 32'(e), 32'h1);
    chk("masked_gpio_o", gpio_o, 32'h0);
`endif

    // Reset while a response is pending
    txn(3'd0, BASE + 32'h4, 4'hF, 32'h1234_5678, 2'd0, rd, e, dop);
    a_valid = 1; a_opcode = 3'd4; a_address = BASE + 32'h4; a_mask = 4'hF;
    d_ready = 0;
    @(negedge clk);
    a_valid = 0;
    chk("pre_reset_d_valid", 32'(d_valid), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_d_valid", 32'(d_valid), 32'h0);
    chk("async_reset_a_ready", 32'(a_ready), 32'h1);
    chk("async_reset_gpio_o", gpio_o, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    d_ready = 1;

    // Randomized traffic
    repeat (3000) begin
      @(negedge clk);
      a_valid = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 7))
        0, 1:    a_opcode = 3'd0;
        2, 3:    a_opcode = 3'd1;
        4, 5, 6: a_opcode = 3'd4;
        default: a_opcode = 3'($urandom);
      endcase
      r = int'($urandom_range(0, 9));
      if (r < 7)       a_address = BASE + 4 * $urandom_range(0, 7);
      else if (r == 7) a_address = BASE + $urandom_range(0, 63);
      else if (r == 8) a_address = BASE + 32'h40 + 4 * $urandom_range(0, 15);
      else             a_address = $urandom;
      a_size   = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd2;
      a_mask   = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      a_data   = $urandom;
      a_source = 2'($urandom);
      a_param  = 3'($urandom);
      d_ready  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) gpio_i = gpio_i ^ (32'h1 << $urandom_range(0, 31));
    end
    @(negedge clk);
    a_valid = 0;
    d_ready = 1;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
